// File: rtl/bcd_alu_pkg.sv
// bcd_alu_pkg: opcodes, FSM states and BCD helpers shared by the BCD ALU files.
package bcd_alu_pkg;
  localparam int BCD_DIGIT_W = 4;
  localparam logic [2:0] OP_SUM = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_EXP = 3'b100;
  typedef enum logic [1:0] {S_IDLE, S_ADDSUB, S_MUL_STEP, S_FIN} state_t;
  function automatic logic [BCD_DIGIT_W-1:0] nines(input logic [BCD_DIGIT_W-1:0] d);
    return 4'd9 - d;
  endfunction
endpackage

// File: rtl/bcd_digit_adder.sv
// bcd_digit_adder: one BCD digit add with carry in/out and +6 decimal correction.
module bcd_digit_adder (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_s,
  output logic       o_cout
);
  logic [4:0] w_sum;
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b} + {4'b0, i_cin};
  assign o_cout = w_sum > 5'd9;
  assign o_s    = o_cout ? w_sum[3:0] + 4'd6 : w_sum[3:0];
endmodule

// File: rtl/bcd_seq_alu.sv
// bcd_seq_alu: sequential sign-magnitude BCD ALU, ADD/SUB in 2 cycles, digit-serial MUL.
// Define BCD_ALU_MUL_EN to build the multiplier; otherwise MUL reports flag_err.
module bcd_seq_alu
  import bcd_alu_pkg::*;
#(
  parameter int DIGIT_NUM = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [2:0]                       operation,
  input  logic [BCD_DIGIT_W*DIGIT_NUM-1:0] operand0,
  input  logic                             operand0_sign,
  input  logic [BCD_DIGIT_W*DIGIT_NUM-1:0] operand1,
  input  logic                             operand1_sign,
  output logic                             busy,
  output logic                             done,
  output logic [BCD_DIGIT_W*DIGIT_NUM-1:0] result,
  output logic                             result_sign,
  output logic                             flag_ov,
  output logic                             flag_err
);
  localparam int D = BCD_DIGIT_W;
  localparam int W = D * DIGIT_NUM;
  state_t r_state, w_next;
  logic [W-1:0] r_a, r_b, r_res, r_result;
  logic r_sa, r_sb, r_err, r_neg, r_tsign, r_tov;
  logic r_busy, r_done, r_result_sign, r_flag_ov, r_flag_err;
  logic [W-1:0] w_b9, w_res9, w_ca, w_cb, w_sum, w_fin;
  logic [DIGIT_NUM:0] w_c;
  logic [2*DIGIT_NUM-1:0] w_bad;
  logic w_cin, w_eq, w_mul, w_err;
`ifdef BCD_ALU_MUL_EN
  localparam int IW = $clog2(DIGIT_NUM + 1);
  logic [W-1:0] r_hi, r_lo, w_hi_sh, w_lo_sh;
  logic [D-1:0] r_ext, r_cnt;
  logic [IW-1:0] r_idx;
  logic w_mul_last;
  assign w_mul      = operation == OP_MUL;
  assign w_hi_sh    = {r_ext, r_hi[W-1:D]};
  assign w_lo_sh    = {r_hi[D-1:0], r_lo[W-1:D]};
  assign w_mul_last = r_cnt == '0 && r_idx == IW'(DIGIT_NUM);
`else
  assign w_mul = 1'b0;
`endif
  for (genvar i = 0; i < DIGIT_NUM; i++) begin : g_dig
    assign w_b9[i*D +: D]   = nines(r_b[i*D +: D]);
    assign w_res9[i*D +: D] = nines(r_res[i*D +: D]);
    assign w_bad[i]             = operand0[i*D +: D] > 4'd9;
    assign w_bad[DIGIT_NUM + i] = operand1[i*D +: D] > 4'd9;
    bcd_digit_adder u_add (
      .i_a    (w_ca[i*D +: D]),
      .i_b    (w_cb[i*D +: D]),
      .i_cin  (w_c[i]),
      .o_s    (w_sum[i*D +: D]),
      .o_cout (w_c[i+1])
    );
  end
  assign w_c[0] = w_cin;
  assign w_err  = (|w_bad) || !(operation == OP_SUM || operation == OP_SUB || w_mul);
  assign w_eq   = r_sa == r_sb;
  assign w_fin  = r_neg ? w_sum : r_res;
  // One ripple chain: add/10's-complement subtract, final negation in FIN, MUL accumulate.
  always_comb begin
    w_ca  = r_a;
    w_cb  = w_eq ? r_b : w_b9;
    w_cin = ~w_eq;
    if (r_state == S_FIN) begin
      w_ca  = w_res9;
      w_cb  = '0;
      w_cin = 1'b1;
    end
`ifdef BCD_ALU_MUL_EN
    if (r_state == S_MUL_STEP) begin
      w_ca  = r_hi;
      w_cb  = r_a;
      w_cin = 1'b0;
    end
`endif
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     w_next = start ? ((w_mul && !w_err) ? S_MUL_STEP : S_ADDSUB) : S_IDLE;
      S_ADDSUB:   w_next = S_FIN;
`ifdef BCD_ALU_MUL_EN
      S_MUL_STEP: w_next = w_mul_last ? S_FIN : S_MUL_STEP;
`endif
      default:    w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) r_state <= rst ? S_IDLE : w_next;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
      r_res <= '0;
      r_sa <= 1'b0;
      r_sb <= 1'b0;
      r_err <= 1'b0;
      r_neg <= 1'b0;
      r_tsign <= 1'b0;
      r_tov <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_result <= '0;
      r_result_sign <= 1'b0;
      r_flag_ov <= 1'b0;
      r_flag_err <= 1'b0;
`ifdef BCD_ALU_MUL_EN
      r_hi <= '0;
      r_lo <= '0;
      r_ext <= '0;
      r_cnt <= '0;
      r_idx <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_a <= operand0;
          r_b <= operand1;
          r_sa <= operand0_sign;
          r_sb <= operand1_sign ^ (operation == OP_SUB);
          r_err <= w_err;
          r_busy <= 1'b1;
`ifdef BCD_ALU_MUL_EN
          r_hi <= '0;
          r_lo <= '0;
          r_ext <= '0;
          r_cnt <= '0;
          r_idx <= '0;
`endif
        end
        S_ADDSUB: begin
          r_res <= w_sum;
          r_tov <= w_eq & w_c[DIGIT_NUM];
          r_neg <= ~w_eq & ~w_c[DIGIT_NUM];
          r_tsign <= r_sa ^ (~w_eq & ~w_c[DIGIT_NUM]);
        end
`ifdef BCD_ALU_MUL_EN
        // Right-shifting accumulator: low product digits retire into r_lo, LSD of operand1 first.
        S_MUL_STEP: if (r_cnt != '0) begin
          r_hi <= w_sum;
          r_ext <= r_ext + {3'b0, w_c[DIGIT_NUM]};
          r_cnt <= r_cnt - 4'd1;
        end else begin
          r_hi <= w_hi_sh;
          r_lo <= w_lo_sh;
          r_ext <= '0;
          r_cnt <= r_b[D-1:0];
          r_b <= r_b >> D;
          r_idx <= r_idx + IW'(1);
          r_res <= w_lo_sh;
          r_tov <= |w_hi_sh;
          r_tsign <= r_sa ^ r_sb;
          r_neg <= 1'b0;
        end
`endif
        default: begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
          r_result <= r_err ? '0 : w_fin;
          r_result_sign <= ~r_err & r_tsign & (|w_fin);
          r_flag_ov <= ~r_err & r_tov;
          r_flag_err <= r_err;
        end
      endcase
    end
  end
  assign busy        = r_busy;
  assign done        = r_done;
  assign result      = r_result;
  assign result_sign = r_result_sign;
  assign flag_ov     = r_flag_ov;
  assign flag_err    = r_flag_err;
endmodule

// File: tb/tb_bcd_seq_alu.sv
// tb_bcd_seq_alu: directed checks of bcd_seq_alu at DIGIT_NUM=4, with or without BCD_ALU_MUL_EN.
module tb_bcd_seq_alu;
  import bcd_alu_pkg::*;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [2:0] operation = '0;
  logic [15:0] operand0 = '0, operand1 = '0, result;
  logic operand0_sign = 1'b0, operand1_sign = 1'b0;
  logic busy, done, result_sign, flag_ov, flag_err;
  int n_vec = 0, n_miss = 0;
  typedef struct packed {
    logic [2:0] op; logic [15:0] a; logic sa; logic [15:0] b; logic sb;
    logic [15:0] r; logic s; logic ov; logic err; logic [7:0] lat;
  } vec_t;

  bcd_seq_alu #(.DIGIT_NUM(4)) dut (
    .clk(clk), .rst(rst), .start(start), .operation(operation),
    .operand0(operand0), .operand0_sign(operand0_sign),
    .operand1(operand1), .operand1_sign(operand1_sign),
    .busy(busy), .done(done), .result(result), .result_sign(result_sign),
    .flag_ov(flag_ov), .flag_err(flag_err)
  );

  always #5 clk = ~clk;

  task automatic do_op(input logic [2:0] op, input logic [15:0] a, input logic sa,
                       input logic [15:0] b, input logic sb, input bit now, output int lat);
    if (!now) @(negedge clk);
    operation = op; operand0 = a; operand0_sign = sa; operand1 = b; operand1_sign = sb;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({busy, done, result, result_sign, flag_ov, flag_err} !== 21'b0) begin
      n_miss++;
      $display("FAIL reset_hold got busy=%b done=%b res=%h s=%b ov=%b err=%b want all 0",
               busy, done, result, result_sign, flag_ov, flag_err);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if ({busy, done, result, result_sign, flag_ov, flag_err} !== 21'b0) begin
      n_miss++;
      $display("FAIL reset_idle got busy=%b done=%b res=%h s=%b ov=%b err=%b want all 0",
               busy, done, result, result_sign, flag_ov, flag_err);
    end
  endtask

  task automatic test_addsub_err;
    vec_t q[$];
    vec_t v;
    int lat;
    q.push_back(vec_t'{OP_SUM, 16'h0123, 1'b0, 16'h0456, 1'b0, 16'h0579, 1'b0, 1'b0, 1'b0, 8'd2});
    q.push_back(vec_t'{OP_SUM, 16'h9999, 1'b0, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'd2});
    q.push_back(vec_t'{OP_SUB, 16'h0012, 1'b0, 16'h0345, 1'b0, 16'h0333, 1'b1, 1'b0, 1'b0, 8'd2});
    q.push_back(vec_t'{OP_SUM, 16'h0050, 1'b1, 16'h0050, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'd2});
    q.push_back(vec_t'{OP_SUB, 16'h0100, 1'b1, 16'h0025, 1'b1, 16'h0075, 1'b1, 1'b0, 1'b0, 8'd2});
    q.push_back(vec_t'{OP_SUM, 16'h0999, 1'b1, 16'h0001, 1'b1, 16'h1000, 1'b1, 1'b0, 1'b0, 8'd2});
    q.push_back(vec_t'{OP_SUM, 16'h0005, 1'b0, 16'h0010, 1'b1, 16'h0005, 1'b1, 1'b0, 1'b0, 8'd2});
    q.push_back(vec_t'{OP_SUB, 16'h9999, 1'b1, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'd2});
    q.push_back(vec_t'{OP_SUM, 16'h00A1, 1'b0, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'd2});
    q.push_back(vec_t'{OP_SUB, 16'h0001, 1'b1, 16'h0F00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'd2});
    q.push_back(vec_t'{OP_DIV, 16'h0010, 1'b0, 16'h0002, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'd2});
    q.push_back(vec_t'{OP_EXP, 16'h0002, 1'b1, 16'h0003, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'd2});
    q.push_back(vec_t'{3'b111, 16'h0002, 1'b0, 16'h0003, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'd2});
    for (int k = 0; k < q.size(); k++) begin
      v = q[k];
      do_op(v.op, v.a, v.sa, v.b, v.sb, 1'b0, lat);
      n_vec++;
      if ({done, busy, result, result_sign, flag_ov, flag_err} !== {1'b1, 1'b0, v.r, v.s, v.ov, v.err}) begin
        n_miss++;
        $display("FAIL addsub[%0d] got done=%b busy=%b res=%h s=%b ov=%b err=%b want done=1 busy=0 res=%h s=%b ov=%b err=%b",
                 k, done, busy, result, result_sign, flag_ov, flag_err, v.r, v.s, v.ov, v.err);
      end
      n_vec++;
      if (lat !== int'(v.lat)) begin
        n_miss++;
        $display("FAIL addsub_lat[%0d] got %0d want %0d", k, lat, v.lat);
      end
    end
  endtask

  task automatic test_mul;
    vec_t q[$];
    vec_t v;
    int lat;
`ifdef BCD_ALU_MUL_EN
    q.push_back(vec_t'{OP_MUL, 16'h0012, 1'b1, 16'h0034, 1'b0, 16'h0408, 1'b1, 1'b0, 1'b0, 8'd13});
    q.push_back(vec_t'{OP_MUL, 16'h0100, 1'b0, 16'h0100, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'd7});
    q.push_back(vec_t'{OP_MUL, 16'h0025, 1'b1, 16'h0004, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0, 8'd10});
    q.push_back(vec_t'{OP_MUL, 16'h0012, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'd6});
    q.push_back(vec_t'{OP_MUL, 16'h0999, 1'b0, 16'h0009, 1'b0, 16'h8991, 1'b0, 1'b0, 1'b0, 8'd15});
    q.push_back(vec_t'{OP_MUL, 16'h12A4, 1'b0, 16'h0002, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'd2});
`else
    q.push_back(vec_t'{OP_MUL, 16'h0012, 1'b1, 16'h0034, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'd2});
`endif
    for (int k = 0; k < q.size(); k++) begin
      v = q[k];
      do_op(v.op, v.a, v.sa, v.b, v.sb, 1'b0, lat);
      n_vec++;
      if ({done, busy, result, result_sign, flag_ov, flag_err} !== {1'b1, 1'b0, v.r, v.s, v.ov, v.err}) begin
        n_miss++;
        $display("FAIL mul[%0d] got done=%b busy=%b res=%h s=%b ov=%b err=%b want done=1 busy=0 res=%h s=%b ov=%b err=%b",
                 k, done, busy, result, result_sign, flag_ov, flag_err, v.r, v.s, v.ov, v.err);
      end
      n_vec++;
      if (lat !== int'(v.lat)) begin
        n_miss++;
        $display("FAIL mul_lat[%0d] got %0d want %0d", k, lat, v.lat);
      end
    end
  endtask

  task automatic test_busy_ignore;
    bit seen;
    @(negedge clk);
    operation = OP_SUM; operand0 = 16'h0123; operand0_sign = 1'b0;
    operand1 = 16'h0456; operand1_sign = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    operation = OP_SUB; operand0 = 16'h0999; operand1 = 16'h0001;
    n_vec++;
    if (busy !== 1'b1) begin
      n_miss++;
      $display("FAIL busy_set got %b want 1", busy);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    n_vec++;
    if ({done, result, result_sign} !== {1'b1, 16'h0579, 1'b0}) begin
      n_miss++;
      $display("FAIL busy_ignore got done=%b res=%h s=%b want done=1 res=0579 s=0", done, result, result_sign);
    end
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if ({seen, result} !== {1'b0, 16'h0579}) begin
      n_miss++;
      $display("FAIL busy_no_extra got extra_done=%b res=%h want extra_done=0 res=0579", seen, result);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    do_op(OP_SUM, 16'h0123, 1'b0, 16'h0456, 1'b0, 1'b0, lat);
    n_vec++;
    if ({done, result} !== {1'b1, 16'h0579}) begin
      n_miss++;
      $display("FAIL b2b_first got done=%b res=%h want done=1 res=0579", done, result);
    end
    do_op(OP_SUM, 16'h0200, 1'b0, 16'h0300, 1'b0, 1'b1, lat);
    n_vec++;
    if ({lat, result, result_sign} !== {32'd2, 16'h0500, 1'b0}) begin
      n_miss++;
      $display("FAIL b2b_second got lat=%0d res=%h s=%b want lat=2 res=0500 s=0", lat, result, result_sign);
    end
  endtask

  task automatic test_abort;
    int lat;
    bit seen;
    do_op(OP_SUM, 16'h0123, 1'b1, 16'h0456, 1'b1, 1'b0, lat);
    n_vec++;
    if ({result, result_sign} !== {16'h0579, 1'b1}) begin
      n_miss++;
      $display("FAIL abort_pre got res=%h s=%b want res=0579 s=1", result, result_sign);
    end
    @(negedge clk);
`ifdef BCD_ALU_MUL_EN
    operation = OP_MUL; operand0 = 16'h0012; operand1 = 16'h0099;
`else
    operation = OP_SUM; operand0 = 16'h0012; operand1 = 16'h0099;
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
`ifdef BCD_ALU_MUL_EN
    repeat (3) @(posedge clk);
    #1;
`endif
    n_vec++;
    if (busy !== 1'b1) begin
      n_miss++;
      $display("FAIL abort_busy got %b want 1", busy);
    end
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    n_vec++;
    if ({busy, done, result, result_sign, flag_ov, flag_err} !== 21'b0) begin
      n_miss++;
      $display("FAIL abort_outputs got busy=%b done=%b res=%h s=%b ov=%b err=%b want all 0",
               busy, done, result, result_sign, flag_ov, flag_err);
    end
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_miss++;
      $display("FAIL abort_no_done got done seen=%b want 0", seen);
    end
  endtask

  initial begin
    test_reset;
    test_addsub_err;
    test_mul;
    test_busy_ignore;
    test_back_to_back;
    test_abort;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
